// File: rtl/apb_slave_responder21_pkg.sv
// rtl/apb_slave_responder21_pkg.sv - shared types, constants and address check for the APB21 responder
package apb_slave_responder_pkg21;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } resp_state_e21;

   localparam logic [7:0] ERR_CNT_MAX21 = 8'hFF;

   // Arguments are widened to 64 bits so base + span never wraps.
   function automatic logic addr_err21(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] span);
      return (addr[1:0] != 2'b00) || (addr < base) || (addr >= base + span);
   endfunction

endpackage

// File: rtl/apb_slave_responder21_mem.sv
// rtl/apb_slave_responder21_mem.sv - flop-array word memory, one write port, one combinational read port
module apb_resp_mem21 #(
   parameter int MEM_DEPTH21 = 16,
   parameter int DATA_W      = 32,
   parameter int IDX_W       = $clog2(MEM_DEPTH21)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [MEM_DEPTH21];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH21; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_responder21.sv
// rtl/apb_slave_responder21.sv - memory-backed APB slave with programmable wait states and error responses
module apb_slave_responder21
   import apb_slave_responder_pkg21::*;
#(
   parameter int                       PADDR_WIDTH21  = 32,
   parameter int                       PWDATA_WIDTH21 = 32,
   parameter int                       PRDATA_WIDTH21 = 32,
   parameter int                       MEM_DEPTH21    = 16,
   parameter logic [PADDR_WIDTH21-1:0] BASE_ADDR21    = '0
) (
   input  logic                      pclock21,
   input  logic                      preset21,
   input  logic [PADDR_WIDTH21-1:0]  paddr21,
   input  logic                      prwd21,
   input  logic [PWDATA_WIDTH21-1:0] pwdata21,
   input  logic                      psel21,
   input  logic                      penable21,
   input  logic [3:0]                wait_cycles21,
   output logic [PRDATA_WIDTH21-1:0] prdata21,
   output logic                      pready21,
   output logic                      pslverr21,
   output logic [7:0]                err_count21
);

   localparam int IDX_W = $clog2(MEM_DEPTH21);

   resp_state_e21             state, nxt_state;
   logic [3:0]                cnt, nxt_cnt;
   logic [IDX_W-1:0]          lat_idx, nxt_idx;
   logic                      lat_wr, nxt_wr;
   logic                      lat_err, nxt_err;
   logic [PWDATA_WIDTH21-1:0] lat_wdata;
   logic                      setup, complete, mem_we;
   logic [PWDATA_WIDTH21-1:0] mem_rdata;

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_idx   = lat_idx;
      nxt_wr    = lat_wr;
      nxt_err   = lat_err;
      setup     = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (psel21 && !penable21) begin
               setup     = 1'b1;
               nxt_idx   = paddr21[2 +: IDX_W];
               nxt_wr    = prwd21;
               nxt_err   = addr_err21(64'(paddr21), 64'(BASE_ADDR21), 64'(MEM_DEPTH21) * 64'd4);
               nxt_cnt   = wait_cycles21;
               nxt_state = (wait_cycles21 == 4'd0) ? READY : WAIT;
            end
         end
         WAIT: begin
            if (!psel21) begin
               nxt_state = IDLE;
               nxt_cnt   = 4'd0;
            end else begin
               nxt_cnt = cnt - 4'd1;
               if (cnt == 4'd1) nxt_state = READY;
            end
         end
         READY: begin
            complete  = psel21;
            nxt_state = IDLE;
            nxt_cnt   = 4'd0;
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Memory is only written as a transfer leaves READY, so reading at nxt_idx never races a write.
   assign mem_we = complete && lat_wr && !lat_err;

   apb_resp_mem21 #(
      .MEM_DEPTH21 (MEM_DEPTH21),
      .DATA_W      (PWDATA_WIDTH21),
      .IDX_W       (IDX_W)
   ) u_mem (
      .clk   (pclock21),
      .rst   (preset21),
      .we    (mem_we),
      .waddr (lat_idx),
      .wdata (lat_wdata),
      .raddr (nxt_idx),
      .rdata (mem_rdata)
   );

   always_ff @(posedge pclock21 or posedge preset21) begin
      if (preset21) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         lat_idx     <= '0;
         lat_wr      <= 1'b0;
         lat_err     <= 1'b0;
         lat_wdata   <= '0;
         prdata21    <= '0;
         pready21    <= 1'b0;
         pslverr21   <= 1'b0;
         err_count21 <= 8'd0;
      end else begin
         state   <= nxt_state;
         cnt     <= nxt_cnt;
         lat_idx <= nxt_idx;
         lat_wr  <= nxt_wr;
         lat_err <= nxt_err;
         if (setup) lat_wdata <= pwdata21;
         pready21  <= (nxt_state == READY);
         pslverr21 <= (nxt_state == READY) && nxt_err;
         prdata21  <= ((nxt_state == READY) && !nxt_err && !nxt_wr) ? PRDATA_WIDTH21'(mem_rdata) : '0;
         if (complete && lat_err && (err_count21 != ERR_CNT_MAX21))
            err_count21 <= err_count21 + 8'd1;
      end
   end

endmodule

// File: tb/tb_apb_slave_responder21.sv
// tb/tb_apb_slave_responder21.sv - directed self-checking bench for apb_slave_responder21
module tb_apb_slave_responder21;

   logic        pclock21 = 1'b0;
   logic        preset21;
   logic [31:0] paddr21;
   logic        prwd21;
   logic [31:0] pwdata21;
   logic        psel21;
   logic        penable21;
   logic [3:0]  wait_cycles21;
   logic [31:0] prdata21;
   logic        pready21;
   logic        pslverr21;
   logic [7:0]  err_count21;

   int n_checks = 0;
   int n_pass   = 0;

   apb_slave_responder21 dut (
      .pclock21      (pclock21),
      .preset21      (preset21),
      .paddr21       (paddr21),
      .prwd21        (prwd21),
      .pwdata21      (pwdata21),
      .psel21        (psel21),
      .penable21     (penable21),
      .wait_cycles21 (wait_cycles21),
      .prdata21      (prdata21),
      .pready21      (pready21),
      .pslverr21     (pslverr21),
      .err_count21   (err_count21)
   );

   always #5 pclock21 = ~pclock21;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge pclock21);
      #1;
   endtask

   // One complete transfer; wait_cycles21 is scrambled after setup to show it is ignored mid-transfer.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] wc, output logic [31:0] rd, output logic err,
                       output int lat);
      psel21 = 1'b1; penable21 = 1'b0; prwd21 = wr;
      paddr21 = addr; pwdata21 = data; wait_cycles21 = wc;
      step();
      penable21 = 1'b1;
      wait_cycles21 = ~wc;
      lat = 1;
      while (!pready21 && lat < 20) begin
         step();
         lat++;
      end
      rd  = prdata21;
      err = pslverr21;
      step();
      check("pready_one_cycle", {31'd0, pready21}, 32'd0);
      psel21 = 1'b0; penable21 = 1'b0;
   endtask

   logic [31:0] rd;
   logic        err;
   int          lat;

   initial begin
      preset21 = 1'b1; psel21 = 1'b0; penable21 = 1'b0; prwd21 = 1'b0;
      paddr21 = '0; pwdata21 = '0; wait_cycles21 = '0;
      step();
      step();
      check("rst_pready",  {31'd0, pready21},  32'd0);
      check("rst_pslverr", {31'd0, pslverr21}, 32'd0);
      check("rst_prdata",  prdata21,           32'd0);
      check("rst_errcnt",  {24'd0, err_count21}, 32'd0);
      preset21 = 1'b0;
      step();

      // write then read back-to-back, zero wait
      xfer(1'b1, 32'h04, 32'hA5A5_0001, 4'd0, rd, err, lat);
      check("wr04_lat", lat, 1);
      check("wr04_err", {31'd0, err}, 32'd0);
      xfer(1'b0, 32'h04, 32'h0, 4'd0, rd, err, lat);
      check("rd04_lat",  lat, 1);
      check("rd04_data", rd, 32'hA5A5_0001);
      check("rd04_err",  {31'd0, err}, 32'd0);
      check("idle_prdata", prdata21, 32'd0);

      // three wait states
      xfer(1'b0, 32'h08, 32'h0, 4'd3, rd, err, lat);
      check("rd08_lat",  lat, 4);
      check("rd08_data", rd, 32'd0);

      // out-of-range and unaligned writes
      xfer(1'b1, 32'h40, 32'h1111_2222, 4'd0, rd, err, lat);
      check("wr40_err", {31'd0, err}, 32'd1);
      xfer(1'b1, 32'h05, 32'h3333_4444, 4'd1, rd, err, lat);
      check("wr05_err", {31'd0, err}, 32'd1);
      check("wr05_lat", lat, 2);
      check("errcnt_2", {24'd0, err_count21}, 32'd2);
      xfer(1'b0, 32'h00, 32'h0, 4'd0, rd, err, lat);
      check("rd00_unchanged", rd, 32'd0);
      xfer(1'b0, 32'h04, 32'h0, 4'd0, rd, err, lat);
      check("rd04_unchanged", rd, 32'hA5A5_0001);
      xfer(1'b0, 32'h41, 32'h0, 4'd0, rd, err, lat);
      check("rd41_err",   {31'd0, err}, 32'd1);
      check("rd41_data0", rd, 32'd0);
      check("errcnt_3",   {24'd0, err_count21}, 32'd3);

      // aborted write: psel drops after two access cycles
      psel21 = 1'b1; penable21 = 1'b0; prwd21 = 1'b1;
      paddr21 = 32'h0C; pwdata21 = 32'hCAFE_F00D; wait_cycles21 = 4'd5;
      step();
      penable21 = 1'b1;
      check("abort_acc1", {31'd0, pready21}, 32'd0);
      step();
      check("abort_acc2", {31'd0, pready21}, 32'd0);
      psel21 = 1'b0; penable21 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("abort_nopready", {31'd0, pready21}, 32'd0);
      end
      check("abort_errcnt", {24'd0, err_count21}, 32'd3);
      xfer(1'b0, 32'h0C, 32'h0, 4'd0, rd, err, lat);
      check("rd0c_after_abort", rd, 32'd0);
      check("rd0c_lat", lat, 1);

      // counter saturation
      for (int i = 0; i < 256; i++) xfer(1'b1, 32'h80, 32'h0, 4'd0, rd, err, lat);
      check("errcnt_sat", {24'd0, err_count21}, 32'd255);

      // reset while READY of a good read
      psel21 = 1'b1; penable21 = 1'b0; prwd21 = 1'b0; paddr21 = 32'h04; wait_cycles21 = 4'd0;
      step();
      penable21 = 1'b1;
      check("rdy_pre_pready", {31'd0, pready21}, 32'd1);
      check("rdy_pre_prdata", prdata21, 32'hA5A5_0001);
      #2 preset21 = 1'b1;
      #1;
      check("rdy_rst_pready", {31'd0, pready21}, 32'd0);
      check("rdy_rst_prdata", prdata21, 32'd0);
      check("rdy_rst_errcnt", {24'd0, err_count21}, 32'd0);
      psel21 = 1'b0; penable21 = 1'b0;
      preset21 = 1'b0;
      step();

      // reset during WAIT of a write to 0x00
      psel21 = 1'b1; penable21 = 1'b0; prwd21 = 1'b1;
      paddr21 = 32'h00; pwdata21 = 32'hDEAD_BEEF; wait_cycles21 = 4'd4;
      step();
      penable21 = 1'b1;
      step();
      #2 preset21 = 1'b1;
      #1;
      check("wait_rst_pready",  {31'd0, pready21},  32'd0);
      check("wait_rst_pslverr", {31'd0, pslverr21}, 32'd0);
      check("wait_rst_prdata",  prdata21,           32'd0);
      psel21 = 1'b0; penable21 = 1'b0;
      preset21 = 1'b0;
      step();
      xfer(1'b0, 32'h00, 32'h0, 4'd0, rd, err, lat);
      check("rd00_after_rst", rd, 32'd0);
      xfer(1'b0, 32'h04, 32'h0, 4'd2, rd, err, lat);
      check("rd04_cleared", rd, 32'd0);
      check("rd04_w2_lat",  lat, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
